// File: rtl/restoring_divider_4bit_pkg.sv
// Shared constants for the 4-bit restoring divider: operand width and FSM state encoding.
package restoring_divider_4bit_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/borrow_look_ahead_subtractor_4bit.sv
// Combinational 4-bit subtractor d = a - b - bin with all borrows computed in parallel.
module borrow_look_ahead_subtractor_4bit
    import restoring_divider_4bit_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] brw;

    assign g = ~a & b;
    assign p = ~(a ^ b);

    // brw[i] is the borrow into bit i; each is a flat sum of products of g/p/bin.
    assign brw[0] = bin;
    assign brw[1] = g[0] | (p[0] & bin);
    assign brw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign brw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & bin);
    assign bout   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & bin);

    assign d = a ^ b ^ brw;

endmodule

// File: rtl/restoring_divider_4bit.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per clock, MSB first.
//  state | meaning
//  IDLE  | ready for a new operation; results of the last one are held
//  RUN   | one restoring step per edge, cnt selects the dividend bit
//  DONE  | single-cycle completion pulse, then back to IDLE
module restoring_divider_4bit #(
    parameter int WIDTH = restoring_divider_4bit_pkg::WIDTH
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    import restoring_divider_4bit_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   r;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   r_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-2:0] q_acc;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             q_bit;
    logic             accept;

    // Shift the partial remainder left and bring in the next dividend bit.
    assign t     = (WIDTH+1)'({r, dvd_q[cnt]});
    assign q_bit = t[WIDTH] | ~bout;
    assign r_nxt = q_bit ? {1'b0, diff} : t;

    borrow_look_ahead_subtractor_4bit u_sub (
        .a    (t[WIDTH-1:0]),
        .b    (dvs_q),
        .bin  (1'b0),
        .d    (diff),
        .bout (bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                ready  = 1'b1;
                accept = start;
                if (start) state_nxt = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            r           <= '0;
            cnt         <= '0;
            q_acc       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            dvd_q <= dividend;
                            dvs_q <= divisor;
                            r     <= '0;
                            q_acc <= '0;
                            cnt   <= CNT_W'(WIDTH - 1);
                        end
                    end
                end
                RUN: begin
                    r <= r_nxt;
                    if (cnt == '0) begin
                        quotient    <= {q_acc, q_bit};
                        remainder   <= r_nxt[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end else begin
                        q_acc <= {q_acc[WIDTH-3:0], q_bit};
                        cnt   <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider_4bit.sv
// Self-checking bench: directed corner cases, random and exhaustive operands vs. an arithmetic model.
module tb_restoring_divider_4bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       ready;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int accepted = 0;

    restoring_divider_4bit #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from a point just after a falling edge and check it against plain arithmetic.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit scramble, input string tag);
        int         k;
        int         elat;
        logic [3:0] eq;
        logic [3:0] er;
        logic       ez;
        if (b == 0) begin
            eq = 4'hF; er = a; ez = 1'b1; elat = 1;
        end else begin
            eq = a / b; er = a % b; ez = 1'b0; elat = 5;
        end
        k = 0;
        while (ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check({tag, "_ready"}, ready, 1);
        start = 1'b1; dividend = a; divisor = b;
        accepted++;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, ready, 0);
        if (scramble) begin
            dividend = 4'($urandom);
            divisor  = 4'($urandom);
        end
        k = 1;
        while (done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check({tag, "_latency"}, k, elat);
        check({tag, "_quot"}, quotient, eq);
        check({tag, "_rem"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, ez);
        @(negedge clk);
        check({tag, "_done_once"}, done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        #1 rst_n = 1'b0;
        #11;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_dbz", div_by_zero, 0);

        // First edge after reset release must accept.
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd13, 4'd4, 1'b1, "d13_4");
        #1 check("d13_4_done_count", done_cnt, accepted);

        run_op(4'd15, 4'd1, 1'b1, "d15_1");
        run_op(4'd15, 4'd15, 1'b1, "d15_15");
        run_op(4'd9, 4'd12, 1'b1, "d9_12");
        run_op(4'd0, 4'd7, 1'b1, "d0_7");
        run_op(4'd7, 4'd0, 1'b1, "d7_0");
        run_op(4'd15, 4'd1, 1'b0, "dbz_clear");

        // Busy start: 2/1 held on start throughout 14/3 must wait for ready.
        start = 1'b1; dividend = 4'd14; divisor = 4'd3;
        accepted++;
        @(negedge clk);
        dividend = 4'd2; divisor = 4'd1;
        k = 1;
        while (done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check("busy_lat1", k, 5);
        check("busy_quot1", quotient, 4);
        check("busy_rem1", remainder, 2);
        @(negedge clk);
        check("busy_ready", ready, 1);
        accepted++;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check("busy_lat2", k, 5);
        check("busy_quot2", quotient, 2);
        check("busy_rem2", remainder, 0);
        @(negedge clk);
        #1 check("busy_done_count", done_cnt, accepted);

        // Reset in the second RUN cycle, with nonzero results held from 7/0.
        run_op(4'd7, 4'd0, 1'b0, "pre_rst");
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_quot", quotient, 0);
        check("mid_rst_rem", remainder, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_rst_no_done", done_cnt, accepted);
        @(negedge clk);
        run_op(4'd10, 4'd3, 1'b1, "d10_3");

        repeat (60) begin
            logic [3:0] a;
            logic [3:0] b;
            a = 4'($urandom_range(0, 15));
            b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            run_op(a, b, 1'b1, $sformatf("rnd_%0d_%0d", a, b));
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), 1'b1, $sformatf("exh_%0d_%0d", a, b));
            end
        end

        #1 check("total_done_count", done_cnt, accepted);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
